// File: rtl/dtn_output_receive_buffer_if.sv
// Message interfaces between the transport network and a PE.
// The nonblocking flavour has no back-pressure; the blocking one adds ready.
interface message_interface_nonblocking #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64
);
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    modport producer (output valid, addr, data);
    modport consumer (input  valid, addr, data);
endinterface

interface message_interface #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64
);
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    modport producer (output valid, addr, data, input  ready);
    modport consumer (input  valid, addr, data, output ready);
endinterface

// File: rtl/dtn_output_receive_buffer.sv
// Receive buffer on a network output: absorbs every delivered message into a
// first-word-fall-through FIFO and re-presents it to the PE with valid/ready.
module dtn_output_receive_buffer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int AF_MARGIN  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    message_interface_nonblocking.consumer in,
    message_interface.producer             out,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           almost_full,
    output logic                           overflow,
    output logic [15:0]                    drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LEVEL   = LW'(DEPTH - AF_MARGIN);

    // Address and data share one word so an entry can never be split.
    logic [EW-1:0] mem [DEPTH];

    logic [PW-1:0] wptr_reg,  wptr_next;
    logic [PW-1:0] rptr_reg,  rptr_next;
    logic [LW-1:0] level_reg, level_next;
    logic          af_reg,    af_next;
    logic          ovf_reg,   ovf_next;
    logic [15:0]   drop_reg,  drop_next;

    logic full;
    logic pop;
    logic push;
    logic drop;

    // A full FIFO still accepts when the head leaves on the same edge.
    assign full = (level_reg == FULL_LEVEL);
    assign pop  = (level_reg != '0) && out.ready;
    assign push = in.valid && (!full || pop);
    assign drop = in.valid && full && !pop;

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        level_next = level_reg;
        ovf_next   = ovf_reg;
        drop_next  = drop_reg;

        if (push) wptr_next = wptr_reg + 1'b1;
        if (pop)  rptr_next = rptr_reg + 1'b1;

        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase

        if (drop) begin
            ovf_next = 1'b1;
            if (drop_reg != 16'hFFFF) drop_next = drop_reg + 16'd1;
        end

        af_next = (level_next >= AF_LEVEL);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            level_reg <= '0;
            af_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            drop_reg  <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            level_reg <= level_next;
            af_reg    <= af_next;
            ovf_reg   <= ovf_next;
            drop_reg  <= drop_next;
        end
    end

    // Storage has no reset: stale contents are hidden behind level == 0.
    always_ff @(posedge clock) begin
        if (push) mem[wptr_reg] <= {in.addr, in.data};
    end

    assign out.valid = (level_reg != '0);
    assign {out.addr, out.data} = mem[rptr_reg];

    assign level       = level_reg;
    assign almost_full = af_reg;
    assign overflow    = ovf_reg;
    assign drop_count  = drop_reg;
endmodule

// File: tb/tb_dtn_output_receive_buffer.sv
// Directed bench for dtn_output_receive_buffer with a small queue scoreboard.
module tb_dtn_output_receive_buffer;
    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AFM   = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    message_interface_nonblocking #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) in_if ();
    message_interface             #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) out_if ();

    logic [4:0]  level;
    logic        almost_full;
    logic        overflow;
    logic [15:0] drop_count;

    dtn_output_receive_buffer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in          (in_if),
        .out         (out_if),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [AW+DW-1:0] q[$];
    int               m_drops = 0;
    bit               m_ovf   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One clock with the given inputs; scoreboard follows the same edge.
    task automatic step(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit r);
        bit full_m, pop_m;
        in_if.valid  = v;
        in_if.addr   = a;
        in_if.data   = d;
        out_if.ready = r;
        full_m = (q.size() == DEPTH);
        pop_m  = (q.size() != 0) && r;
        @(posedge clock);
        if (pop_m) q.delete(0);
        if (v && (!full_m || pop_m)) q.push_back({a, d});
        else if (v) begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
        end
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"}, 64'(out_if.valid), 64'(q.size() != 0));
        check({tag, "_level"}, 64'(level), 64'(q.size()));
        check({tag, "_af"}, 64'(almost_full), 64'(q.size() >= DEPTH - AFM));
        check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        check({tag, "_drops"}, 64'(drop_count), 64'(m_drops));
        if (q.size() != 0) begin
            check({tag, "_addr"}, 64'(out_if.addr), 64'(q[0][AW+DW-1:DW]));
            check({tag, "_data"}, out_if.data, q[0][DW-1:0]);
        end
    endtask

    task automatic clear_model();
        q.delete();
        m_drops = 0;
        m_ovf   = 0;
    endtask

    initial begin
        in_if.valid  = 1'b0;
        in_if.addr   = '0;
        in_if.data   = '0;
        out_if.ready = 1'b0;

        // Test 1: reset values, single message, hold then pop.
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", 64'(out_if.valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_af", 64'(almost_full), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drops", 64'(drop_count), 64'd0);
        reset = 1'b0;
        in_if.valid = 1'b1;
        in_if.addr  = 4'd3;
        in_if.data  = 64'hDEAD_BEEF_0000_0001;
        #1;
        check("t1_no_bypass", 64'(out_if.valid), 64'd0);
        step(1, 4'd3, 64'hDEAD_BEEF_0000_0001, 0);
        check("t1_valid", 64'(out_if.valid), 64'd1);
        check("t1_addr", 64'(out_if.addr), 64'd3);
        check("t1_data", out_if.data, 64'hDEAD_BEEF_0000_0001);
        check("t1_level", 64'(level), 64'd1);
        step(0, 4'd0, 64'd0, 0);
        check("t1_hold_data", out_if.data, 64'hDEAD_BEEF_0000_0001);
        check_state("t1_hold");
        step(0, 4'd0, 64'd0, 1);
        check("t1_pop_valid", 64'(out_if.valid), 64'd0);
        check("t1_pop_level", 64'(level), 64'd0);

        // Test 2: fill to 16; almost_full rises after the 12th push.
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 4'(i), 64'(i), 0);
            check($sformatf("t2_level_%0d", i), 64'(level), 64'(i + 1));
            check($sformatf("t2_af_%0d", i), 64'(almost_full), 64'(i >= 11));
        end
        check("t2_ovf", 64'(overflow), 64'd0);
        check("t2_head", out_if.data, 64'd0);

        // Test 3: three pushes into a full FIFO are dropped.
        for (int i = 0; i < 3; i++) step(1, 4'hF, 64'hBAD0 + 64'(i), 0);
        check("t3_ovf", 64'(overflow), 64'd1);
        check("t3_drops", 64'(drop_count), 64'd3);
        check("t3_level", 64'(level), 64'd16);
        check("t3_head", out_if.data, 64'd0);

        // Test 4: simultaneous pop/push at full, 40 cycles of streaming.
        for (int k = 0; k < 40; k++) begin
            check($sformatf("t4_head_%0d", k), out_if.data,
                  (k < 16) ? 64'(k) : 64'(100 + k - 16));
            check_state($sformatf("t4_%0d", k));
            step(1, 4'(k), 64'(100 + k), 1);
        end
        check("t4_drops", 64'(drop_count), 64'd3);
        for (int k = 0; k < 20 && q.size() != 0; k++) step(0, 4'd0, 64'd0, 1);
        check_state("t4_drained");

        // Test 5: asynchronous reset in the middle of a burst.
        for (int i = 0; i < 7; i++) step(1, 4'(i), 64'h7000 + 64'(i), 0);
        check("t5_level", 64'(level), 64'd7);
        check("t5_ovf", 64'(overflow), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 64'(out_if.valid), 64'd0);
        check("t5_rst_level", 64'(level), 64'd0);
        check("t5_rst_ovf", 64'(overflow), 64'd0);
        check("t5_rst_drops", 64'(drop_count), 64'd0);
        clear_model();
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1, 4'd5, 64'h55, 0);
        check("t5_after_data", out_if.data, 64'h55);
        check("t5_after_level", 64'(level), 64'd1);
        step(0, 4'd0, 64'd0, 1);
        check_state("t5_after_pop");

        // Test 6: drop counter saturation.
        for (int i = 0; i < DEPTH; i++) step(1, 4'(i), 64'h6000 + 64'(i), 0);
        for (int i = 0; i < 65534; i++) step(1, 4'hA, 64'hDEAD, 0);
        check("t6_drops_fffe", 64'(drop_count), 64'hFFFE);
        for (int i = 0; i < 6; i++) step(1, 4'hA, 64'hDEAD, 0);
        check("t6_drops_sat", 64'(drop_count), 64'hFFFF);
        check("t6_ovf", 64'(overflow), 64'd1);
        check("t6_level", 64'(level), 64'd16);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t6_drain_%0d", i), out_if.data, 64'h6000 + 64'(i));
            step(0, 4'd0, 64'd0, 1);
        end
        check_state("t6_empty");
        step(1, 4'd9, 64'h1234, 0);
        check_state("t6_resume");
        step(0, 4'd0, 64'd0, 1);
        check_state("t6_resume_pop");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/dtn_output_receive_buffer.md
Name: dtn_output_receive_buffer

Overview:
Receive-side endpoint for one output port of the pipelined transport network, which delivers messages over the non-blocking interface and cannot be stalled. The block absorbs every delivered message into an on-chip FIFO and re-presents it to the downstream PE over the blocking valid/ready message interface. It flags overflow, counts dropped messages, and raises an almost-full indication that upstream flow control (arbiter throttling) uses. One instance sits on each network output.

Parameters:
ADDR_WIDTH, 4, width of the message address field (source/destination tag).
DATA_WIDTH, 64, width of the message payload.
DEPTH, 16, FIFO entries; power of two, >= 2.
AF_MARGIN, 4, almost_full asserts when free entries <= AF_MARGIN; 0 <= AF_MARGIN < DEPTH.

Ports:
clock  in  1  single clock, all state on rising edge.
reset  in  1  asynchronous, active-high; clears all state.
in  message_interface_nonblocking.consumer  -  network side: in.valid (1), in.addr (ADDR_WIDTH), in.data (DATA_WIDTH); no ready.
out  message_interface.producer  -  PE side: out.valid (1), out.addr (ADDR_WIDTH), out.data (DATA_WIDTH), out.ready (1, input).
level  out  $clog2(DEPTH+1)  current occupancy.
almost_full  out  1  level >= DEPTH - AF_MARGIN.
overflow  out  1  sticky; set on the first dropped message.
drop_count  out  16  dropped messages, saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync-safe deassert handled externally): write/read pointers = 0, level = 0, out.valid = 0, almost_full = 0 (unless AF_MARGIN >= DEPTH, which is illegal), overflow = 0, drop_count = 0. Memory contents are don't-care. Reset mid-traffic discards all buffered messages. No message is emitted during reset or in the first cycle after it.
- Push: in.valid is sampled on the clock edge. {addr,data} are written at wptr if the FIFO is not full, or if it is full and a pop occurs in the same cycle. wptr wraps modulo DEPTH.
- Pop: occurs when out.valid && out.ready at the edge. rptr advances modulo DEPTH.
- Output: out.valid = (level != 0). out.addr/out.data = entry at rptr, presented combinationally from storage (first-word fall-through). They are stable while out.valid && !out.ready.
- Latency: a message pushed at edge N is visible on out at cycle N+1 when the FIFO was empty. There is no same-cycle in-to-out bypass.
- Occupancy update per edge:
  - push only: level + 1
  - pop only: level - 1
  - both: unchanged
  - neither: unchanged
- Drop: in.valid while full with no pop in that cycle. The message is discarded, overflow is set to 1 and held until reset, and drop_count is incremented unless already 0xFFFF. Pointers and level are unchanged.
- almost_full, level and overflow are registered, derived from the post-edge state; no combinational path from in.* to them.
- Ordering: strict FIFO. addr and data of an entry are never split or reordered.
- No X propagation: out.addr/out.data when out.valid = 0 are don't-care but must not be used by downstream.
- Target: 120-250 lines RTL. Storage is inferred as a register array. Single always_ff block with async reset for pointers and status.

Test Plan:
1. Reset, then push addr=3 data=0xDEAD_BEEF_0000_0001 at edge 1 with out.ready=0 -> out.valid=1 from cycle 2 with that addr/data, held stable; level=1. Then raise ready -> popped, out.valid=0, level=0.
2. Push 16 messages back-to-back (data=i) with out.ready=0 -> level reaches 16. almost_full rises after the 12th push. No drop. Then ready=1 -> data 0..15 emerge in order, one per cycle.
3. FIFO full, ready=0, push 3 more messages -> overflow=1, drop_count=3, level stays 16, buffered contents unchanged.
4. FIFO full, ready=1 and in.valid=1 in the same cycle -> head popped, new message accepted, level stays 16, no drop. Continuous streaming for 40 cycles exercises pointer wrap with correct order.
5. Assert reset asynchronously mid-burst (level=7, overflow=1) -> out.valid, level, overflow and drop_count go to 0 immediately. The next push after deassert appears alone on out.
6. Force 65,540 drops -> drop_count saturates at 0xFFFF. overflow stays 1 and the FIFO keeps operating normally once drained.
